// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard logic (stall unit, forwarding).
//   ADDR_W        register address width
//   NUM_REGS      number of architectural registers (2**ADDR_W)
//   REG_ZERO      hard-wired zero register, never a real dependency
//   reg_addr_t    register address type
//   reg_mask_t    one bit per architectural register
//   stall_cause_t individual stall reasons, OR-ed into the final stall
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0]   reg_addr_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef struct packed {
    logic lu;    // load-use in execute
    logic sb;    // read of a register owned by an in-flight long op
    logic ww;    // long op writing a register that is still pending
    logic full;  // no free long-op slot
  } stall_cause_t;

  // One-hot mask for a register address; callers gate REG_ZERO themselves.
  function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
    return reg_mask_t'(1) << addr;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit_if
// Bundle between the pipeline and the hazard stall unit.
//   Decode   : Rs1_D, Rs2_D, Use1_D, Use2_D, RD_D, LongOp_D
//   Execute  : RD_E, LoadE, RegWriteE, PCSrcE
//   Writeback: LongDone_W, LongRD_W
//   Controls : StallF, StallD, FlushD, FlushE
//   Debug    : Pending (scoreboard bitmap), StallCount (stall cycles)
// The master modport is the pipeline side and the slave modport is the unit.
// -----------------------------------------------------------------------------
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  import hazard_pkg::*;

  reg_addr_t        Rs1_D;
  reg_addr_t        Rs2_D;
  logic             Use1_D;
  logic             Use2_D;
  reg_addr_t        RD_D;
  logic             LongOp_D;
  reg_addr_t        RD_E;
  logic             LoadE;
  logic             RegWriteE;
  logic             PCSrcE;
  logic             LongDone_W;
  reg_addr_t        LongRD_W;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  reg_mask_t        Pending;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output Rs1_D, Rs2_D, Use1_D, Use2_D, RD_D, LongOp_D,
    output RD_E, LoadE, RegWriteE, PCSrcE,
    output LongDone_W, LongRD_W,
    input  StallF, StallD, FlushD, FlushE, Pending, StallCount
  );

  modport slave (
    input  Rs1_D, Rs2_D, Use1_D, Use2_D, RD_D, LongOp_D,
    input  RD_E, LoadE, RegWriteE, PCSrcE,
    input  LongDone_W, LongRD_W,
    output StallF, StallD, FlushD, FlushE, Pending, StallCount
  );

endinterface

// File: rtl/hazard_stall_unit_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Tracks destinations of long-latency ops between issue and writeback.
//   clk, rst   clock and synchronous active-high reset
//   set_en     issue a long op this cycle to set_addr
//   set_addr   destination of the issuing long op
//   clr_en     a long op writes back this cycle to clr_addr
//   clr_addr   destination of the completing long op
//   pending    one bit per register that still awaits a long-op result
//   full       MAX_LONG long ops are outstanding
// -----------------------------------------------------------------------------
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int MAX_LONG = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  output reg_mask_t pending,
  output logic      full
);

  localparam int OUT_W = $clog2(MAX_LONG + 1);

  logic [OUT_W-1:0] outstanding;
  logic             set_hit;
  logic             clr_hit;
  reg_mask_t        set_mask;
  reg_mask_t        clr_mask;

  // Register zero is never tracked, and a writeback for a register that is
  // not pending (e.g. dropped by a reset) must not disturb the count.
  always_comb begin
    set_hit  = set_en && (set_addr != REG_ZERO);
    clr_hit  = clr_en && (clr_addr != REG_ZERO) && pending[clr_addr];
    set_mask = set_hit ? reg_onehot(set_addr) : '0;
    clr_mask = clr_hit ? reg_onehot(clr_addr) : '0;
  end

  // Issue and completion in the same cycle cancel in the count while both
  // bit updates still apply.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      outstanding <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (set_hit && !clr_hit) begin
        outstanding <= outstanding + 1'b1;
      end else if (!set_hit && clr_hit) begin
        outstanding <= outstanding - 1'b1;
      end
    end
  end

  assign full = (outstanding == OUT_W'(MAX_LONG));

endmodule

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Stall/flush controller for hazards forwarding cannot hide: load-use,
// dependencies on in-flight long-latency ops, and taken-branch redirects.
//   clk, rst   clock and synchronous active-high reset
//   hz         hazard_stall_unit_if slave: decode/execute/writeback hazard
//              inputs in; StallF/StallD/FlushD/FlushE, Pending, StallCount out
// -----------------------------------------------------------------------------
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MAX_LONG = 2,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_unit_if.slave hz
);

  reg_mask_t    pending;
  logic         sb_full;
  stall_cause_t cause;
  logic         stall;
  logic         issue;
  logic         stall_f;
  logic         stall_d;
  logic         flush_d;
  logic         flush_e;
  logic [CNT_W-1:0] stall_count;

  reg_scoreboard #(
    .MAX_LONG (MAX_LONG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue),
    .set_addr (hz.RD_D),
    .clr_en   (hz.LongDone_W),
    .clr_addr (hz.LongRD_W),
    .pending  (pending),
    .full     (sb_full)
  );

  // The scoreboard is read before this cycle's writeback clears its bit, so a
  // reader of a completing register still stalls once and proceeds next cycle.
  // A taken branch squashes decode, so it wins over stalls and blocks issue.
  always_comb begin
    cause   = '0;
    stall   = 1'b0;
    issue   = 1'b0;
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (!rst) begin
      cause.lu   = hz.LoadE && hz.RegWriteE && (hz.RD_E != REG_ZERO) &&
                   ((hz.Use1_D && (hz.Rs1_D == hz.RD_E)) ||
                    (hz.Use2_D && (hz.Rs2_D == hz.RD_E)));
      cause.sb   = (hz.Use1_D && pending[hz.Rs1_D]) ||
                   (hz.Use2_D && pending[hz.Rs2_D]);
      cause.ww   = hz.LongOp_D && (hz.RD_D != REG_ZERO) && pending[hz.RD_D];
      cause.full = hz.LongOp_D && sb_full;
      stall      = |cause;
      stall_f    = stall && !hz.PCSrcE;
      stall_d    = stall && !hz.PCSrcE;
      flush_d    = hz.PCSrcE;
      flush_e    = stall || hz.PCSrcE;
      issue      = hz.LongOp_D && !stall && !hz.PCSrcE && (hz.RD_D != REG_ZERO);
    end
  end

  // Saturating count of cycles in which decode was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall_d && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.Pending    = pending;
  assign hz.StallCount = stall_count;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
// Directed vectors for hazard_stall_unit. Each vector records its hand-worked
// controls {StallF,StallD,FlushD,FlushE}, Pending and StallCount in a queue; a
// monitor on the falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

  localparam int CNT_W    = 8;
  localparam int MAX_LONG = 2;
  localparam int SAT      = (1 << CNT_W) - 1;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] pend;
    int          cnt;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   total_checks = 0;
  int   passed_checks = 0;

  hazard_stall_unit_if #(.CNT_W(CNT_W)) hz ();

  hazard_stall_unit #(
    .MAX_LONG (MAX_LONG),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] bit_of(input int idx);
    return 32'd1 << idx;
  endfunction

  // Quiet pipeline: nothing read, nothing in flight, no branch.
  task automatic idle();
    hz.Rs1_D      = '0;
    hz.Rs2_D      = '0;
    hz.Use1_D     = 1'b0;
    hz.Use2_D     = 1'b0;
    hz.RD_D       = '0;
    hz.LongOp_D   = 1'b0;
    hz.RD_E       = '0;
    hz.LoadE      = 1'b0;
    hz.RegWriteE  = 1'b0;
    hz.PCSrcE     = 1'b0;
    hz.LongDone_W = 1'b0;
    hz.LongRD_W   = '0;
  endtask

  // Hold the inputs already set for one cycle, recording what the DUT must
  // show during it, then return to idle just after the next rising edge.
  task automatic applyStimulus(input string nm, input logic [3:0] ctrl,
                               input logic [31:0] pend, input int cnt);
    exp_t e;
    e.name = nm;
    e.ctrl = ctrl;
    e.pend = pend;
    e.cnt  = cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    idle();
  endtask

  // Compare the three observable groups of one expectation.
  task automatic checkOutput(input exp_t e);
    logic [3:0] got_ctrl;
    got_ctrl = {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE};
    total_checks++;
    if (got_ctrl !== e.ctrl)
      $display("[TB] FAIL %s ctrl got %b want %b", e.name, got_ctrl, e.ctrl);
    else
      passed_checks++;
    total_checks++;
    if (hz.Pending !== e.pend)
      $display("[TB] FAIL %s pending got %h want %h", e.name, hz.Pending, e.pend);
    else
      passed_checks++;
    total_checks++;
    if ((^hz.StallCount === 1'bx) || (int'(hz.StallCount) != e.cnt))
      $display("[TB] FAIL %s count got %0d want %0d", e.name, hz.StallCount, e.cnt);
    else
      passed_checks++;
  endtask

  // Monitor: outputs are valid every cycle, so check on each falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
  end

  // Directed sequence following the test plan.
  initial begin
    int waited;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Reset forces controls low even with load-use and branch present.
    hz.LoadE = 1'b1; hz.RegWriteE = 1'b1; hz.RD_E = 5'd5;
    hz.Rs1_D = 5'd5; hz.Use1_D = 1'b1; hz.PCSrcE = 1'b1;
    applyStimulus("reset_forced", 4'b0000, 32'h0, 0);
    rst = 1'b0;

    // Load-use: one stall cycle, then clear.
    hz.LoadE = 1'b1; hz.RegWriteE = 1'b1; hz.RD_E = 5'd5;
    hz.Rs1_D = 5'd5; hz.Use1_D = 1'b1;
    applyStimulus("lu_stall", 4'b1101, 32'h0, 0);
    hz.Rs1_D = 5'd5; hz.Use1_D = 1'b1;
    applyStimulus("lu_after", 4'b0000, 32'h0, 1);

    // Long op to x7, reader stalls until the cycle after writeback.
    hz.LongOp_D = 1'b1; hz.RD_D = 5'd7;
    applyStimulus("long7_issue", 4'b0000, 32'h0, 1);
    hz.Rs1_D = 5'd7; hz.Use1_D = 1'b1;
    applyStimulus("sb7_a", 4'b1101, bit_of(7), 1);
    hz.Rs1_D = 5'd7; hz.Use1_D = 1'b1;
    applyStimulus("sb7_b", 4'b1101, bit_of(7), 2);
    hz.Rs1_D = 5'd7; hz.Use1_D = 1'b1; hz.LongDone_W = 1'b1; hz.LongRD_W = 5'd7;
    applyStimulus("sb7_done", 4'b1101, bit_of(7), 3);
    hz.Rs1_D = 5'd7; hz.Use1_D = 1'b1;
    applyStimulus("sb7_go", 4'b0000, 32'h0, 4);

    // Two outstanding long ops fill the slots; third waits for a completion.
    hz.LongOp_D = 1'b1; hz.RD_D = 5'd3;
    applyStimulus("long3", 4'b0000, 32'h0, 4);
    hz.LongOp_D = 1'b1; hz.RD_D = 5'd4;
    applyStimulus("long4", 4'b0000, bit_of(3), 4);
    hz.LongOp_D = 1'b1; hz.RD_D = 5'd6;
    applyStimulus("full_a", 4'b1101, bit_of(3) | bit_of(4), 4);
    hz.LongOp_D = 1'b1; hz.RD_D = 5'd6; hz.LongDone_W = 1'b1; hz.LongRD_W = 5'd3;
    applyStimulus("full_done3", 4'b1101, bit_of(3) | bit_of(4), 5);
    hz.LongOp_D = 1'b1; hz.RD_D = 5'd6;
    applyStimulus("long6_issue", 4'b0000, bit_of(4), 6);
    applyStimulus("pend_4_6", 4'b0000, bit_of(4) | bit_of(6), 6);
    hz.LongDone_W = 1'b1; hz.LongRD_W = 5'd4;
    applyStimulus("done4", 4'b0000, bit_of(4) | bit_of(6), 6);
    hz.LongDone_W = 1'b1; hz.LongRD_W = 5'd6;
    applyStimulus("done6", 4'b0000, bit_of(6), 6);
    applyStimulus("drained", 4'b0000, 32'h0, 6);

    // Branch beats a load-use stall and squashes a long op in decode.
    hz.LoadE = 1'b1; hz.RegWriteE = 1'b1; hz.RD_E = 5'd5;
    hz.Rs1_D = 5'd5; hz.Use1_D = 1'b1; hz.PCSrcE = 1'b1;
    hz.LongOp_D = 1'b1; hz.RD_D = 5'd9;
    applyStimulus("branch_wins", 4'b0011, 32'h0, 6);
    applyStimulus("branch_no_set", 4'b0000, 32'h0, 6);

    // WAW on a pending register, and a RAW through source 2.
    hz.LongOp_D = 1'b1; hz.RD_D = 5'd10;
    applyStimulus("long10", 4'b0000, 32'h0, 6);
    hz.LongOp_D = 1'b1; hz.RD_D = 5'd10;
    applyStimulus("waw10", 4'b1101, bit_of(10), 6);
    hz.Rs1_D = 5'd10; hz.Rs2_D = 5'd10; hz.Use2_D = 1'b1;
    applyStimulus("raw10_rs2", 4'b1101, bit_of(10), 7);
    hz.Rs1_D = 5'd10; hz.LongDone_W = 1'b1; hz.LongRD_W = 5'd10;
    applyStimulus("unused_rs1", 4'b0000, bit_of(10), 8);
    applyStimulus("clear10", 4'b0000, 32'h0, 8);

    // Register zero never creates a hazard; spurious writeback is ignored.
    hz.LoadE = 1'b1; hz.RegWriteE = 1'b1; hz.RD_E = 5'd0;
    hz.Rs1_D = 5'd0; hz.Use1_D = 1'b1; hz.LongOp_D = 1'b1; hz.RD_D = 5'd0;
    applyStimulus("x0_no_stall", 4'b0000, 32'h0, 8);
    hz.LongDone_W = 1'b1; hz.LongRD_W = 5'd9;
    applyStimulus("spurious9", 4'b0000, 32'h0, 8);
    applyStimulus("x0_no_pend", 4'b0000, 32'h0, 8);
    hz.LoadE = 1'b1; hz.RegWriteE = 1'b1; hz.RD_E = 5'd12;
    hz.Rs2_D = 5'd12; hz.Use2_D = 1'b1;
    applyStimulus("lu_rs2", 4'b1101, 32'h0, 8);
    hz.LoadE = 1'b1; hz.RegWriteE = 1'b1; hz.RD_E = 5'd12; hz.Rs1_D = 5'd12;
    applyStimulus("lu_no_use", 4'b0000, 32'h0, 9);

    // Build up Pending[7] and StallCount=20, then reset mid-operation.
    hz.LongOp_D = 1'b1; hz.RD_D = 5'd7;
    applyStimulus("long7_again", 4'b0000, 32'h0, 9);
    for (int i = 0; i < 11; i++) begin
      hz.Rs1_D = 5'd7; hz.Use1_D = 1'b1;
      applyStimulus("sb7_build", 4'b1101, bit_of(7), 9 + i);
    end
    rst = 1'b1;
    hz.Rs1_D = 5'd7; hz.Use1_D = 1'b1;
    applyStimulus("rst_mid", 4'b0000, bit_of(7), 20);
    rst = 1'b0;
    hz.Rs1_D = 5'd7; hz.Use1_D = 1'b1;
    applyStimulus("post_rst", 4'b0000, 32'h0, 0);

    // Continuous load-use stall drives StallCount to saturation.
    for (int i = 0; i < SAT + 6; i++) begin
      hz.LoadE = 1'b1; hz.RegWriteE = 1'b1; hz.RD_E = 5'd5;
      hz.Rs1_D = 5'd5; hz.Use1_D = 1'b1;
      applyStimulus("sat", 4'b1101, 32'h0, (i < SAT) ? i : SAT);
    end
    applyStimulus("sat_hold", 4'b0000, 32'h0, SAT);

    // Let the monitor drain the queue, bounded.
    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      total_checks++;
      $display("[TB] FAIL drain left %0d want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Stall/flush controller for the 5-stage pipeline. It covers the hazards that operand forwarding cannot resolve:
- load-use in the Execute stage
- long-latency (multi-cycle) writers still in flight
- taken-branch redirects

It keeps a register scoreboard of pending long-latency destinations, set at issue and cleared at writeback. It drives StallF/StallD/FlushD/FlushE to the fetch/decode/execute pipeline registers.

Parameters:
ADDR_W, 5, register address width
NUM_REGS, 32, architectural registers (2**ADDR_W)
MAX_LONG, 2, max long-latency ops outstanding (1..NUM_REGS-1)
CNT_W, 16, stall performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
Rs1_D  in  ADDR_W  decode source 1
Rs2_D  in  ADDR_W  decode source 2
Use1_D  in  1  decode instruction reads Rs1_D
Use2_D  in  1  decode instruction reads Rs2_D
RD_D  in  ADDR_W  decode destination
LongOp_D  in  1  decode instruction is long-latency writer
RD_E  in  ADDR_W  execute destination
LoadE  in  1  execute instruction is a load (ResultSrc = memory)
RegWriteE  in  1  execute instruction writes register
PCSrcE  in  1  taken branch/jump resolved in execute
LongDone_W  in  1  long-latency result written back this cycle
LongRD_W  in  ADDR_W  destination of completing long op
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register (bubble)
Pending  out  NUM_REGS  scoreboard bitmap (debug)
StallCount  out  CNT_W  saturating count of stall cycles

Behaviour:
Reset (rst=1 at clock edge):
- scoreboard, outstanding count and StallCount all go to 0.
- While rst=1, all four control outputs are forced to 0 combinationally.

Control outputs are combinational from current state and inputs. Scoreboard and counters update on the rising edge.

Stall conditions (each evaluated with rst=0):
- lu (load-use): LoadE & RegWriteE & RD_E!=0 & ((Use1_D & Rs1_D==RD_E) | (Use2_D & Rs2_D==RD_E)).
- sb (RAW on pending long op): (Use1_D & Pending[Rs1_D]) | (Use2_D & Pending[Rs2_D]). Register 0 is never pending.
- ww (WAW): LongOp_D & RD_D!=0 & Pending[RD_D].
- full: LongOp_D & outstanding==MAX_LONG.
- stall = lu | sb | ww | full.

Outputs:
- StallF = StallD = stall & ~PCSrcE.
- FlushE = stall | PCSrcE.
- FlushD = PCSrcE.
- A taken branch overrides stalls, because the decode instruction is squashed.

Issue: issue = LongOp_D & ~stall & ~PCSrcE & RD_D!=0.
- On issue: Pending[RD_D] <= 1 and outstanding increments.
- An instruction flushed or stalled in decode never sets a bit.

Completion: LongDone_W & LongRD_W!=0 & Pending[LongRD_W].
- Effect: Pending[LongRD_W] <= 0; outstanding decrements.
- LongDone_W for a non-pending register is ignored.

Same-cycle events:
- Issue and completion together: outstanding is unchanged, and both bit updates apply.
- Completion of register r in the same cycle that decode reads r: stall is still asserted that cycle. The bit clears at the edge, and the instruction proceeds the next cycle.
- Issue to the same register as a same-cycle completion cannot occur (ww stalls).

Latency:
- Load-use stall: exactly 1 cycle.
- Scoreboard stall: lasts until the cycle after LongDone_W.

StallCount increments on every cycle with StallD=1 and saturates at all-ones.

Reset mid-operation clears all pending bits and the outstanding count. In-flight long ops are dropped; the pipeline flush is the caller's responsibility.

Decomposition:
- Shared package (hazard_pkg): ADDR_W, NUM_REGS, REG_ZERO constant. Reused by the forwarding logic.
- One natural sub-module: reg_scoreboard. It holds the Pending bitmap, outstanding counter, set/clear ports and a full flag.
- Stall/flush decode and StallCount stay in the top module.

Test Plan:
1. Load x5 in E (LoadE=1, RegWriteE=1, RD_E=5), decode Rs1_D=5, Use1_D=1 -> one cycle of StallF=StallD=FlushE=1. Next cycle (load has moved on) all 0. StallCount=1.
2. LongOp_D, RD_D=7 issues. A later instruction reads x7 -> stalls every cycle until LongDone_W with LongRD_W=7. It proceeds the cycle after completion, and Pending[7] returns to 0.
3. With MAX_LONG=2, issue long ops to x3 and x4, then a third long op to x6 -> full stall. Completion of x3 -> x6 issues the next cycle, and Pending = bits 4,6.
4. Decode load-use stall with PCSrcE=1 in the same cycle -> StallF=StallD=0, FlushD=FlushE=1. A LongOp_D flushed by that branch does not set its Pending bit.
5. Rs1_D=0 with load to x0, and LongOp_D with RD_D=0 -> no stall, Pending stays 0. Spurious LongDone_W for x9 (not pending) -> no state change.
6. Assert rst with Pending[7]=1 and StallCount=20 -> the next cycle has all outputs 0, Pending=0 and StallCount=0. Drive 2**CNT_W+5 stall cycles -> StallCount saturates at all-ones.
